// File: rtl/ps2_rx_fifo.sv
// PS/2 keyboard receiver: pin synchronisers, 11-bit frame decoder with timeout,
// and a small byte FIFO whose head byte is presented to the core.
module ps2_rx_fifo #(
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 5000,
    parameter int FIFO_DEPTH     = 4,
    parameter int FIFO_AW        = 2
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               ps2_clk,
    input  logic               ps2_data,
    input  logic               ps2_pop,
    output logic [7:0]         ps2_out,
    output logic               ps2_key_pressed,
    output logic [FIFO_AW:0]   fifo_count,
    output logic               frame_error,
    output logic               overflow
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_DATA   = 2'd1;
    localparam logic [1:0] S_PARITY = 2'd2;
    localparam logic [1:0] S_STOP   = 2'd3;

    localparam int              TW     = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [TW-1:0]   T_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [FIFO_AW:0] FULL  = (FIFO_AW + 1)'(FIFO_DEPTH);

    logic [SYNC_STAGES-1:0] clk_sync;
    logic [SYNC_STAGES-1:0] data_sync;
    logic                   clk_prev;
    logic                   fall;
    logic                   bit_in;

    logic [1:0]    state;
    logic [2:0]    bit_cnt;
    logic [7:0]    shreg;
    logic          parity_bit;
    logic [TW-1:0] timeout_ctr;

    logic [7:0]         mem [FIFO_DEPTH];
    logic [FIFO_AW-1:0] rd_ptr;
    logic [FIFO_AW-1:0] wr_ptr;

    logic frame_ok;
    logic push;
    logic start_err;
    logic stop_err;
    logic timeout;
    logic do_pop;
    logic do_push;

    // Sync chains reset high so an idle bus does not look like a falling edge.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            clk_sync  <= '1;
            data_sync <= '1;
            clk_prev  <= 1'b1;
            fall      <= 1'b0;
        end else begin
            clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
            data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data};
            clk_prev  <= clk_sync[SYNC_STAGES-1];
            fall      <= clk_prev & ~clk_sync[SYNC_STAGES-1];
        end
    end

    assign bit_in    = data_sync[SYNC_STAGES-1];
    assign frame_ok  = bit_in & (^{shreg, parity_bit});
    assign push      = fall && (state == S_STOP) && frame_ok;
    assign start_err = fall && (state == S_IDLE) && bit_in;
    assign stop_err  = fall && (state == S_STOP) && !frame_ok;
    assign timeout   = !fall && (state != S_IDLE) && (timeout_ctr == T_LAST);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= S_IDLE;
            bit_cnt     <= '0;
            shreg       <= '0;
            parity_bit  <= 1'b0;
            timeout_ctr <= '0;
            frame_error <= 1'b0;
        end else begin
            frame_error <= start_err | stop_err | timeout;
            if (fall || state == S_IDLE)
                timeout_ctr <= '0;
            else
                timeout_ctr <= timeout_ctr + 1'b1;

            if (timeout) begin
                state <= S_IDLE;
            end else if (fall) begin
                case (state)
                    S_IDLE: begin
                        if (!bit_in) begin
                            state   <= S_DATA;
                            bit_cnt <= '0;
                        end
                    end
                    S_DATA: begin
                        shreg   <= {bit_in, shreg[7:1]};
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == 3'd7)
                            state <= S_PARITY;
                    end
                    S_PARITY: begin
                        parity_bit <= bit_in;
                        state      <= S_STOP;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    // A pop in the same cycle frees a slot, so a push into a full FIFO is still accepted.
    assign do_pop  = ps2_pop && (fifo_count != '0);
    assign do_push = push && ((fifo_count != FULL) || do_pop);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++)
                mem[i] <= '0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            fifo_count <= '0;
            overflow   <= 1'b0;
        end else begin
            overflow <= push && !do_push;
            if (do_push) begin
                mem[wr_ptr] <= shreg;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    assign ps2_key_pressed = (fifo_count != '0);
    assign ps2_out         = ps2_key_pressed ? mem[rd_ptr] : 8'h00;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Scoreboard bench for ps2_rx_fifo: PS/2 frames are bit-banged onto the pins,
// good bytes are queued as expected results and compared as the core pops them.
module tb_ps2_rx_fifo;

    localparam int HALF  = 8;
    localparam int SYNC  = 2;
    localparam int TO    = 5000;
    localparam int DEPTH = 4;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic       ps2_pop = 1'b0;
    logic [7:0] ps2_out;
    logic       ps2_key_pressed;
    logic [2:0] fifo_count;
    logic       frame_error;
    logic       overflow;

    int checks = 0;
    int errors = 0;
    int fe_cnt = 0;
    int ov_cnt = 0;
    int exp_fe = 0;
    int exp_ov = 0;
    logic [7:0] exp_q [$];

    ps2_rx_fifo #(
        .SYNC_STAGES(SYNC),
        .TIMEOUT_CYCLES(TO),
        .FIFO_DEPTH(DEPTH),
        .FIFO_AW(2)
    ) dut (
        .clock(clock),
        .reset(reset),
        .ps2_clk(ps2_clk),
        .ps2_data(ps2_data),
        .ps2_pop(ps2_pop),
        .ps2_out(ps2_out),
        .ps2_key_pressed(ps2_key_pressed),
        .fifo_count(fifo_count),
        .frame_error(frame_error),
        .overflow(overflow)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (frame_error) fe_cnt++;
        if (overflow) ov_cnt++;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic ps2_bit(input logic b);
        ps2_data = b;
        tick(HALF);
        ps2_clk = 1'b0;
        tick(HALF);
        ps2_clk = 1'b1;
    endtask

    // Full frame; optionally pulses ps2_pop exactly in the cycle the stop bit is acted on.
    task automatic send_frame(input logic [7:0] b, input logic par_flip, input logic stop,
                              input logic pop_on_stop);
        logic p;
        p = (~^b) ^ par_flip;
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i]);
        ps2_bit(p);
        ps2_data = stop;
        tick(HALF);
        ps2_clk = 1'b0;
        for (int i = 0; i < HALF; i++) begin
            @(posedge clock);
            #1;
            if (pop_on_stop) begin
                ps2_pop = (i == SYNC);
                if (i == SYNC && exp_q.size() > 0) begin
                    checks++;
                    if (ps2_out !== exp_q[0]) begin
                        errors++;
                        $display("FAIL pop_on_stop_head got %h exp %h", ps2_out, exp_q[0]);
                    end
                    void'(exp_q.pop_front());
                end
            end
        end
        ps2_clk = 1'b1;
        if (!par_flip && stop) begin
            if (exp_q.size() < DEPTH) exp_q.push_back(b);
            else exp_ov++;
        end else begin
            exp_fe++;
        end
        tick(HALF);
    endtask

    task automatic pop_check(input string name);
        logic [7:0] exp;
        exp = (exp_q.size() > 0) ? exp_q[0] : 8'h00;
        checks++;
        if (ps2_out !== exp) begin
            errors++;
            $display("FAIL %s head got %h exp %h", name, ps2_out, exp);
        end
        ps2_pop = 1'b1;
        tick(1);
        ps2_pop = 1'b0;
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        checks++;
        if (fifo_count !== 3'(exp_q.size())) begin
            errors++;
            $display("FAIL %s count got %0d exp %0d", name, fifo_count, exp_q.size());
        end
    endtask

    task automatic test_reset();
        checks++;
        if ({ps2_out, ps2_key_pressed, fifo_count, frame_error, overflow} !== 13'd0) begin
            errors++;
            $display("FAIL reset_outputs got out=%h kp=%b cnt=%0d fe=%b ov=%b exp all 0",
                     ps2_out, ps2_key_pressed, fifo_count, frame_error, overflow);
        end
        reset = 1'b1;
        tick(4);
    endtask

    task automatic test_good_frame();
        send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
        checks++;
        if (ps2_key_pressed !== 1'b1 || ps2_out !== exp_q[0] || fifo_count !== 3'd1) begin
            errors++;
            $display("FAIL good_frame got kp=%b out=%h cnt=%0d exp kp=1 out=%h cnt=1",
                     ps2_key_pressed, ps2_out, fifo_count, exp_q[0]);
        end
        checks++;
        if (fe_cnt !== exp_fe) begin
            errors++;
            $display("FAIL good_frame_err got %0d exp %0d", fe_cnt, exp_fe);
        end
        pop_check("good_frame_pop");
        checks++;
        if (ps2_key_pressed !== 1'b0 || ps2_out !== 8'h00) begin
            errors++;
            $display("FAIL good_frame_empty got kp=%b out=%h exp kp=0 out=00", ps2_key_pressed, ps2_out);
        end
    endtask

    task automatic test_bad_frames();
        send_frame(8'h1C, 1'b1, 1'b1, 1'b0);
        checks++;
        if (fe_cnt !== exp_fe || fifo_count !== 3'd0) begin
            errors++;
            $display("FAIL bad_parity got fe=%0d cnt=%0d exp fe=%0d cnt=0", fe_cnt, fifo_count, exp_fe);
        end
        send_frame(8'h1C, 1'b0, 1'b0, 1'b0);
        checks++;
        if (fe_cnt !== exp_fe || fifo_count !== 3'd0) begin
            errors++;
            $display("FAIL bad_stop got fe=%0d cnt=%0d exp fe=%0d cnt=0", fe_cnt, fifo_count, exp_fe);
        end
    endtask

    task automatic test_overflow();
        for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b0, 1'b1, 1'b0);
        checks++;
        if (fifo_count !== 3'd4 || ov_cnt !== exp_ov || ps2_out !== exp_q[0]) begin
            errors++;
            $display("FAIL overflow got cnt=%0d ov=%0d out=%h exp cnt=4 ov=%0d out=%h",
                     fifo_count, ov_cnt, ps2_out, exp_ov, exp_q[0]);
        end
        while (exp_q.size() > 0) pop_check("overflow_drain");
        checks++;
        if (ps2_key_pressed !== 1'b0 || ps2_out !== 8'h00) begin
            errors++;
            $display("FAIL overflow_empty got kp=%b out=%h exp kp=0 out=00", ps2_key_pressed, ps2_out);
        end
    endtask

    task automatic test_full_pop();
        for (int i = 1; i <= 4; i++) send_frame(8'(i), 1'b0, 1'b1, 1'b0);
        send_frame(8'h05, 1'b0, 1'b1, 1'b1);
        checks++;
        if (fifo_count !== 3'd4 || ov_cnt !== exp_ov) begin
            errors++;
            $display("FAIL full_pop got cnt=%0d ov=%0d exp cnt=4 ov=%0d", fifo_count, ov_cnt, exp_ov);
        end
        while (exp_q.size() > 0) pop_check("full_pop_drain");
    endtask

    task automatic test_timeout();
        int fe0;
        int elapsed;
        logic fired;
        fe0 = fe_cnt;
        fired = 1'b0;
        elapsed = 0;
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_data = 1'b1;
        for (int n = 0; n < TO + 100; n++) begin
            tick(1);
            if (fe_cnt != fe0) begin
                fired = 1'b1;
                elapsed = n;
                break;
            end
        end
        exp_fe++;
        checks++;
        if (!fired || elapsed < TO - 2*HALF - 10 || elapsed > TO + 10) begin
            errors++;
            $display("FAIL timeout got fired=%b after %0d cycles exp near %0d", fired, elapsed, TO - 2*HALF);
        end
        tick(5);
        send_frame(8'hF0, 1'b0, 1'b1, 1'b0);
        checks++;
        if (ps2_out !== 8'hF0 || fifo_count !== 3'd1 || fe_cnt !== exp_fe) begin
            errors++;
            $display("FAIL after_timeout got out=%h cnt=%0d fe=%0d exp out=f0 cnt=1 fe=%0d",
                     ps2_out, fifo_count, fe_cnt, exp_fe);
        end
        pop_check("after_timeout_pop");
    endtask

    task automatic test_reset_mid_frame();
        send_frame(8'h3A, 1'b0, 1'b1, 1'b0);
        ps2_bit(1'b0);
        for (int i = 0; i < 5; i++) ps2_bit(1'(i & 1));
        reset = 1'b0;
        #1;
        exp_q.delete();
        checks++;
        if ({ps2_out, ps2_key_pressed, fifo_count, frame_error, overflow} !== 13'd0) begin
            errors++;
            $display("FAIL reset_mid got out=%h kp=%b cnt=%0d fe=%b ov=%b exp all 0",
                     ps2_out, ps2_key_pressed, fifo_count, frame_error, overflow);
        end
        tick(3);
        ps2_data = 1'b1;
        reset = 1'b1;
        tick(HALF * 4);
        checks++;
        if (fe_cnt !== exp_fe || fifo_count !== 3'd0) begin
            errors++;
            $display("FAIL reset_mid_quiet got fe=%0d cnt=%0d exp fe=%0d cnt=0", fe_cnt, fifo_count, exp_fe);
        end
        send_frame(8'hAA, 1'b0, 1'b1, 1'b0);
        checks++;
        if (ps2_out !== 8'hAA || fifo_count !== 3'd1) begin
            errors++;
            $display("FAIL reset_mid_next got out=%h cnt=%0d exp out=aa cnt=1", ps2_out, fifo_count);
        end
        pop_check("reset_mid_pop");
    endtask

    initial begin
        tick(3);
        test_reset();
        test_good_frame();
        test_bad_frames();
        test_overflow();
        test_full_pop();
        test_timeout();
        test_reset_mid_frame();
        checks++;
        if (fe_cnt !== exp_fe || ov_cnt !== exp_ov) begin
            errors++;
            $display("FAIL pulse_totals got fe=%0d ov=%0d exp fe=%0d ov=%0d", fe_cnt, ov_cnt, exp_fe, exp_ov);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
